// File: rtl/spi_resp_pkg.sv
// Shared encodings for the SPI register responder: frame states, command layout and fill byte.
// Burst addressing is enabled by defining SPI_RESP_BURST_EN.
package spi_resp_pkg;

    localparam logic [1:0] CMD   = 2'd0;
    localparam logic [1:0] WDATA = 2'd1;
    localparam logic [1:0] RDATA = 2'd2;

    localparam int         CMD_RD_BIT = 7;
    localparam logic [6:0] STAT_ADDR  = 7'h7F;
    localparam logic [7:0] FILL_BYTE  = 8'h00;

    // In-bank addresses wrap at count-1; anything outside the bank (incl. status) stays put.
    function automatic logic [6:0] addr_inc(input logic [6:0] addr, input logic [6:0] count);
        if (addr >= count) begin
            return addr;
        end
        return (addr == count - 7'd1) ? 7'd0 : addr + 7'd1;
    endfunction

endpackage

// File: rtl/spi_resp_regbank.sv
// REG_COUNT x 8 register bank with one write port and a read mux that maps
// the read-only status byte at STAT_ADDR and returns FILL_BYTE elsewhere.
module spi_resp_regbank
    import spi_resp_pkg::*;
#(
    parameter int         REG_COUNT = 8,
    parameter logic [7:0] REG_RESET = 8'h00
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [6:0]             i_wr_addr,
    input  logic [7:0]             i_wr_data,
    input  logic [6:0]             i_rd_addr,
    input  logic [7:0]             i_stat,
    output logic [7:0]             o_rd_data,
    output logic [REG_COUNT*8-1:0] o_reg_q
);

    logic [7:0] r_regs [REG_COUNT];

    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            always_ff @(posedge clock) begin
                if (rst) begin
                    r_regs[gi] <= REG_RESET;
                end else if (i_wr_en && i_wr_addr == 7'(gi)) begin
                    r_regs[gi] <= i_wr_data;
                end
            end
            assign o_reg_q[gi*8 +: 8] = r_regs[gi];
        end
    endgenerate

    // REG_COUNT never exceeds 127, so the status address can never alias a bank entry.
    always_comb begin
        o_rd_data = FILL_BYTE;
        if (i_rd_addr == STAT_ADDR) begin
            o_rd_data = i_stat;
        end
        for (int i = 0; i < REG_COUNT; i++) begin
            if (i_rd_addr == 7'(i)) begin
                o_rd_data = r_regs[i];
            end
        end
    end

endmodule

// File: rtl/spi_reg_responder.sv
// Frame decoder between the SPI slave byte interface and the register bank.
// Define SPI_RESP_BURST_EN to auto-increment the address after every data byte.
module spi_reg_responder
    import spi_resp_pkg::*;
#(
    parameter int         REG_COUNT = 8,
    parameter logic [7:0] REG_RESET = 8'h00
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   cs_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_vld,
    output logic [7:0]             tx_data,
    output logic                   tx_vld,
    input  logic                   tx_ready,
    input  logic [7:0]             stat_in,
    output logic [REG_COUNT*8-1:0] reg_q,
    output logic                   wr_stb,
    output logic [6:0]             wr_addr
);

`ifdef SPI_RESP_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       r_cs_meta, r_cs_sync, r_cs_prev;
    logic [1:0] r_state;
    logic [6:0] r_addr;
    logic       r_done;
    logic [7:0] r_tx_data;
    logic       r_tx_vld;
    logic       r_wr_stb;
    logic [6:0] r_wr_addr;

    logic       w_cs_rise;
    logic       w_act;
    logic [6:0] w_next_addr;
    logic [6:0] w_rd_addr;
    logic [7:0] w_rd_data;
    logic       w_wr_en;
    logic       w_unused;

    // The slave captures tx_data on its own; the byte is simply held until the next update.
    assign w_unused = tx_ready;

    assign w_cs_rise   = r_cs_sync & ~r_cs_prev;
    assign w_act       = BURST | ~r_done;
    assign w_next_addr = BURST ? addr_inc(r_addr, 7'(REG_COUNT)) : r_addr;
    assign w_rd_addr   = (r_state == CMD) ? rx_data[6:0] : w_next_addr;
    assign w_wr_en     = rx_vld & ~w_cs_rise & (r_state == WDATA) & w_act
                       & (r_addr < 7'(REG_COUNT));

    spi_resp_regbank #(
        .REG_COUNT (REG_COUNT),
        .REG_RESET (REG_RESET)
    ) u_regbank (
        .clock     (clock),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_addr),
        .i_wr_data (rx_data),
        .i_rd_addr (w_rd_addr),
        .i_stat    (stat_in),
        .o_rd_data (w_rd_data),
        .o_reg_q   (reg_q)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            r_cs_meta <= 1'b1;
            r_cs_sync <= 1'b1;
            r_cs_prev <= 1'b1;
        end else begin
            r_cs_meta <= cs_n;
            r_cs_sync <= r_cs_meta;
            r_cs_prev <= r_cs_sync;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state   <= CMD;
            r_addr    <= 7'd0;
            r_done    <= 1'b0;
            r_tx_data <= FILL_BYTE;
            r_tx_vld  <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= 7'd0;
        end else begin
            r_tx_vld <= 1'b1;
            r_wr_stb <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= r_addr;
            end
            if (w_cs_rise) begin
                r_state   <= CMD;
                r_done    <= 1'b0;
                r_tx_data <= FILL_BYTE;
            end else if (rx_vld) begin
                case (r_state)
                    CMD: begin
                        r_addr <= rx_data[6:0];
                        r_done <= 1'b0;
                        if (rx_data[CMD_RD_BIT]) begin
                            r_state   <= RDATA;
                            r_tx_data <= w_rd_data;
                        end else begin
                            r_state <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (w_act) begin
                            r_addr <= w_next_addr;
                            r_done <= 1'b1;
                        end
                    end
                    RDATA: begin
                        // Without bursting the single response has now gone out; pad the rest.
                        r_tx_data <= (BURST && w_act) ? w_rd_data : FILL_BYTE;
                        if (w_act) begin
                            r_addr <= w_next_addr;
                            r_done <= 1'b1;
                        end
                    end
                    default: r_state <= CMD;
                endcase
            end
        end
    end

    assign tx_data = r_tx_data;
    assign tx_vld  = r_tx_vld;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed self-checking bench for spi_reg_responder (REG_COUNT = 8, REG_RESET = 0).
// Expectations follow SPI_RESP_BURST_EN when the build defines it.
module tb_spi_reg_responder;

    logic        clock = 1'b0;
    logic        rst;
    logic        cs_n;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_ready;
    logic [7:0]  stat_in;
    logic [63:0] reg_q;
    logic        wr_stb;
    logic [6:0]  wr_addr;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [63:0] exp_q;

    always #5 clock = ~clock;

    spi_reg_responder #(
        .REG_COUNT (8),
        .REG_RESET (8'h00)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .cs_n     (cs_n),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .tx_data  (tx_data),
        .tx_vld   (tx_vld),
        .tx_ready (tx_ready),
        .stat_in  (stat_in),
        .reg_q    (reg_q),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Byte is presented for one cycle; returns at the negedge after it was consumed.
    task automatic send(input logic [7:0] b);
        @(negedge clock);
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge clock);
        rx_vld  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic frame_begin;
        cs_n = 1'b0;
        cycles(4);
    endtask

    task automatic frame_end;
        cs_n = 1'b1;
        cycles(6);
    endtask

    initial begin
        rst      = 1'b1;
        cs_n     = 1'b1;
        rx_data  = 8'h00;
        rx_vld   = 1'b0;
        tx_ready = 1'b0;
        stat_in  = 8'h00;
        exp_q    = 64'h0;

        cycles(3);
        check("rst_tx_vld",  64'(tx_vld),  64'h0);
        check("rst_tx_data", 64'(tx_data), 64'h0);
        check("rst_wr_stb",  64'(wr_stb),  64'h0);
        check("rst_wr_addr", 64'(wr_addr), 64'h0);
        check("rst_reg_q",   reg_q,        64'h0);
        rst = 1'b0;
        cycles(1);
        check("post_rst_tx_vld", 64'(tx_vld), 64'h1);

        // Write single {0x03, 0x5A}
        frame_begin();
        send(8'h03);
        check("wr_cmd_no_stb", 64'(wr_stb), 64'h0);
        send(8'h5A);
        exp_q = 64'h0000_0000_5A00_0000;
        check("wr_stb",   64'(wr_stb),  64'h1);
        check("wr_addr",  64'(wr_addr), 64'h3);
        check("wr_reg_q", reg_q,        exp_q);
        cycles(1);
        check("wr_stb_pulse_end", 64'(wr_stb), 64'h0);
        frame_end();

        // Preload reg2 = 0xC3
        frame_begin();
        send(8'h02);
        send(8'hC3);
        frame_end();
        exp_q = 64'h0000_0000_5AC3_0000;
        check("preload_reg_q", reg_q, exp_q);

        // Read single {0x82, 0x00}: fill during the command, value one cycle after it
        frame_begin();
        tx_ready = 1'b1;
        @(negedge clock);
        rx_data = 8'h82;
        rx_vld  = 1'b1;
        check("rd_cmd_cycle_fill", 64'(tx_data), 64'h0);
        @(negedge clock);
        rx_vld  = 1'b0;
        rx_data = 8'h00;
        check("rd_single_data", 64'(tx_data), 64'hC3);
        send(8'h00);
        tx_ready = 1'b0;
        frame_end();
        check("frame_end_fill", 64'(tx_data), 64'h0);

        // Status read and dropped status write
        stat_in = 8'h9E;
        frame_begin();
        send(8'hFF);
        check("stat_read", 64'(tx_data), 64'h9E);
        send(8'h00);
        frame_end();
        frame_begin();
        send(8'h7F);
        send(8'h11);
        check("stat_wr_no_stb", 64'(wr_stb), 64'h0);
        check("stat_wr_reg_q",  reg_q,       exp_q);
        frame_end();

        // Burst {0x06, 0xA0, 0xA1, 0xA2}
        frame_begin();
        send(8'h06);
        send(8'hA0);
        check("burst_b0_stb",  64'(wr_stb),  64'h1);
        check("burst_b0_addr", 64'(wr_addr), 64'h6);
        send(8'hA1);
`ifdef SPI_RESP_BURST_EN
        check("burst_b1_stb",  64'(wr_stb),  64'h1);
        check("burst_b1_addr", 64'(wr_addr), 64'h7);
        send(8'hA2);
        check("burst_b2_addr", 64'(wr_addr), 64'h0);
        exp_q = 64'hA1A0_0000_5AC3_00A2;
`else
        check("burst_b1_no_stb", 64'(wr_stb), 64'h0);
        send(8'hA2);
        check("burst_b2_no_stb", 64'(wr_stb), 64'h0);
        exp_q = 64'h00A0_0000_5AC3_0000;
`endif
        frame_end();
        check("burst_reg_q", reg_q, exp_q);

        // Out of range write and read
        frame_begin();
        send(8'h0A);
        send(8'h33);
        check("oor_wr_no_stb", 64'(wr_stb), 64'h0);
        check("oor_wr_reg_q",  reg_q,       exp_q);
        frame_end();
        frame_begin();
        send(8'h8A);
        check("oor_rd_fill", 64'(tx_data), 64'h0);
        send(8'h00);
        frame_end();

        // Abort after a read command, then a fresh write frame
        frame_begin();
        send(8'h81);
        frame_end();
        frame_begin();
        send(8'h01);
        check("abort_cmd_no_stb", 64'(wr_stb), 64'h0);
        send(8'h44);
        exp_q[15:8] = 8'h44;
        check("abort_wr_stb",  64'(wr_stb),  64'h1);
        check("abort_wr_addr", 64'(wr_addr), 64'h1);
        check("abort_reg_q",   reg_q,        exp_q);
        frame_end();

        // Reset in the middle of a frame
        frame_begin();
        send(8'h05);
        send(8'h77);
        exp_q[47:40] = 8'h77;
        check("midrst_pre_reg_q", reg_q, exp_q);
        @(negedge clock);
        rst = 1'b1;
        cycles(2);
        check("midrst_tx_vld", 64'(tx_vld), 64'h0);
        check("midrst_reg_q",  reg_q,       64'h0);
        rst = 1'b0;
        cycles(1);
        check("midrst_tx_vld_back", 64'(tx_vld), 64'h1);
        send(8'h04);
        send(8'h12);
        check("midrst_new_cmd_stb",  64'(wr_stb),  64'h1);
        check("midrst_new_cmd_addr", 64'(wr_addr), 64'h4);
        check("midrst_new_reg_q",    reg_q,        64'h0000_0012_0000_0000);
        frame_end();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
